// File: rtl/trig_lut_sequencer.sv
// Sine-LUT front end: reduces a degree angle mod 360, maps it to quadrant/index,
// fires one LUT lookup and returns the captured double. Define TRIG_FAST_REDUCE_EN for 16x360 reduction steps.
module trig_lut_sequencer #(
    parameter int ANGLE_W  = 16,
    parameter int LUT_IN_W = 32,
    parameter int RESULT_W = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_op,
    input  logic [ANGLE_W-1:0]  in_angle,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RESULT_W-1:0] out_data,
    output logic                lut_en,
    output logic [1:0]          lut_quadrant,
    output logic [LUT_IN_W-1:0] lut_angle,
    input  logic [RESULT_W-1:0] lut_data
);

    localparam int A_W = ANGLE_W + 1;

    localparam logic [A_W-1:0] DEG_90  = A_W'(32'd90);
    localparam logic [A_W-1:0] DEG_180 = A_W'(32'd180);
    localparam logic [A_W-1:0] DEG_270 = A_W'(32'd270);
    localparam logic [A_W-1:0] DEG_360 = A_W'(32'd360);
`ifdef TRIG_FAST_REDUCE_EN
    localparam logic [A_W-1:0] DEG_5760 = A_W'(32'd5760);
`endif

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REDUCE   = 3'd1,
        MAP      = 3'd2,
        LUT_REQ  = 3'd3,
        LUT_WAIT = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [A_W-1:0]        a_r;
    logic [A_W-1:0]        a_step_s;
    logic                  reduce_more_s;
    logic [1:0]            map_quad_s;
    logic [A_W-1:0]        map_idx_s;
    logic [1:0]            quad_r;
    logic [LUT_IN_W-1:0]   idx_r;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic                  lut_en_r;
    logic [RESULT_W-1:0]   out_data_r;
    logic                  accept_s;

    assign accept_s     = (state_r == IDLE) && in_valid && in_ready_r;
    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign lut_en       = lut_en_r;
    assign lut_quadrant = quad_r;
    assign lut_angle    = idx_r;

    // Selects the next subtraction step of the modulo-360 reduction
    always_comb begin
        a_step_s      = a_r;
        reduce_more_s = 1'b0;
`ifdef TRIG_FAST_REDUCE_EN
        if (a_r >= DEG_5760) begin
            a_step_s      = a_r - DEG_5760;
            reduce_more_s = 1'b1;
        end else if (a_r >= DEG_360) begin
            a_step_s      = a_r - DEG_360;
            reduce_more_s = 1'b1;
        end else begin
            a_step_s      = a_r;
            reduce_more_s = 1'b0;
        end
`else
        if (a_r >= DEG_360) begin
            a_step_s      = a_r - DEG_360;
            reduce_more_s = 1'b1;
        end else begin
            a_step_s      = a_r;
            reduce_more_s = 1'b0;
        end
`endif
    end

    // Folds the reduced angle into quadrant and first-quadrant index
    always_comb begin
        map_quad_s = 2'd0;
        map_idx_s  = a_r;
        if (a_r <= DEG_90) begin
            map_quad_s = 2'd0;
            map_idx_s  = a_r;
        end else if (a_r <= DEG_180) begin
            map_quad_s = 2'd1;
            map_idx_s  = DEG_180 - a_r;
        end else if (a_r <= DEG_270) begin
            map_quad_s = 2'd2;
            map_idx_s  = a_r - DEG_180;
        end else begin
            map_quad_s = 2'd3;
            map_idx_s  = DEG_360 - a_r;
        end
    end

    // Next-state decode of the sequencer FSM
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = REDUCE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REDUCE: begin
                if (reduce_more_s) begin
                    state_next_s = REDUCE;
                end else begin
                    state_next_s = MAP;
                end
            end
            MAP:      state_next_s = LUT_REQ;
            LUT_REQ:  state_next_s = LUT_WAIT;
            LUT_WAIT: state_next_s = DONE;
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default:  state_next_s = IDLE;
        endcase
    end

    // State, datapath and registered handshake/LUT outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            a_r         <= '0;
            quad_r      <= 2'd0;
            idx_r       <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            lut_en_r    <= 1'b0;
            out_data_r  <= '0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
            lut_en_r    <= (state_next_s == LUT_REQ);
            if (accept_s) begin
                // The extra top bit absorbs the cosine +90 offset
                a_r <= in_op ? ({1'b0, in_angle} + DEG_90) : {1'b0, in_angle};
            end else if ((state_r == REDUCE) && reduce_more_s) begin
                a_r <= a_step_s;
            end
            if (state_r == MAP) begin
                quad_r <= map_quad_s;
                idx_r  <= LUT_IN_W'(map_idx_s);
            end
            // lut_data is only driven in the cycle after lut_en
            if (state_r == LUT_WAIT) begin
                out_data_r <= lut_data;
            end
        end
    end

endmodule

// File: tb/tb_trig_lut_sequencer.sv
// Scoreboard bench for trig_lut_sequencer: directed sin/cos vectors, LUT model,
// latency, backpressure and mid-operation reset checks.
module tb_trig_lut_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_op;
    logic [15:0] in_angle;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        lut_en;
    logic [1:0]  lut_quadrant;
    logic [31:0] lut_angle;
    logic [63:0] lut_drv = 64'd0;
    logic        lut_oe  = 1'b0;
    wire  [63:0] lut_data = lut_oe ? lut_drv : {64{1'bz}};

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int lut_pulses = 0;

    typedef struct {
        logic [63:0] data;
        int          lat;
        int          acc;
    } exp_t;
    typedef struct {
        logic [1:0]  q;
        logic [31:0] i;
    } lut_exp_t;

    exp_t     exp_q[$];
    lut_exp_t lut_q[$];

    trig_lut_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_angle     (in_angle),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .lut_en       (lut_en),
        .lut_quadrant (lut_quadrant),
        .lut_angle    (lut_angle),
        .lut_data     (lut_data)
    );

    always #5 clk = ~clk;

    // Cycle counter: value at a negedge is the index of the preceding posedge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Sine LUT model: registered output, high-Z outside the cycle after lut_en
    function automatic logic [63:0] lut_val(input logic [1:0] q, input logic [31:0] i);
        logic [63:0] m;
        case (i)
            32'd0:   m = 64'h0000000000000000;
            32'd15:  m = 64'h3fd0907dc1930690;
            32'd30:  m = 64'h3fdfffffffffffff;
            32'd60:  m = 64'h3febb67ae8584caa;
            32'd75:  m = 64'h3feee8dd4748bf15;
            32'd90:  m = 64'h3ff0000000000000;
            default: m = {32'hdeadbeef, i};
        endcase
        if (q[1] && (m != 64'd0)) m[63] = 1'b1;
        return m;
    endfunction

    always @(posedge clk) begin
        lut_oe <= lut_en;
        if (lut_en) lut_drv <= lut_val(lut_quadrant, lut_angle);
    end

    // Monitors: compare LUT requests and results against the scoreboard queues
    logic valid_seen = 1'b0;
    logic prev_lut_en = 1'b0;
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (lut_en === 1'b1) begin
                lut_pulses++;
                if (prev_lut_en) fail("lut_en_single_cycle");
                if (lut_q.size() == 0) begin
                    fail("lut_unexpected");
                end else begin
                    lut_exp_t le;
                    le = lut_q.pop_front();
                    check("lut_quadrant", {62'd0, lut_quadrant}, {62'd0, le.q});
                    check("lut_angle", {32'd0, lut_angle}, {32'd0, le.i});
                end
            end
            if ((out_valid === 1'b1) && !valid_seen) begin
                valid_seen = 1'b1;
                if (exp_q.size() == 0) begin
                    fail("out_unexpected");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("latency", 64'(cyc - e.acc), 64'(e.lat));
                end
            end
            if ((out_valid === 1'b1) && (out_ready === 1'b1)) valid_seen = 1'b0;
        end else begin
            valid_seen = 1'b0;
        end
        prev_lut_en = (lut_en === 1'b1);
    end

    // Driver: present a request, wait (bounded) for in_ready, record expectations
    task automatic issue(input logic op, input logic [15:0] ang, input logic [1:0] q,
                         input logic [31:0] i, input logic [63:0] d, input int lat);
        int    n;
        exp_t  e;
        lut_exp_t le;
        in_valid = 1'b1;
        in_op    = op;
        in_angle = ang;
        n = 0;
        while ((in_ready !== 1'b1) && (n < 400)) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            fail("in_ready_wait");
        end else begin
            e.data = d; e.lat = lat; e.acc = cyc + 1;
            exp_q.push_back(e);
            le.q = q; le.i = i;
            lut_q.push_back(le);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

`ifdef TRIG_FAST_REDUCE_EN
    localparam int LAT_MAX = 21;
`else
    localparam int LAT_MAX = 186;
`endif

    initial begin
        int n;
        int snap;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_op     = 1'b0;
        in_angle  = 16'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_lut_en", {63'd0, lut_en}, 64'd0);
        check("rst_lut_quadrant", {62'd0, lut_quadrant}, 64'd0);
        check("rst_lut_angle", {32'd0, lut_angle}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        //    op    angle       q     i       data                     latency
        issue(1'b0, 16'd30,    2'd0, 32'd30, 64'h3fdfffffffffffff, 4);
        issue(1'b1, 16'd60,    2'd1, 32'd30, 64'h3fdfffffffffffff, 4);
        issue(1'b0, 16'd210,   2'd2, 32'd30, 64'hbfdfffffffffffff, 4);
        issue(1'b0, 16'd300,   2'd3, 32'd60, 64'hbfebb67ae8584caa, 4);
        issue(1'b1, 16'd270,   2'd0, 32'd0,  64'h0000000000000000, 5);
        issue(1'b0, 16'd0,     2'd0, 32'd0,  64'h0000000000000000, 4);
        issue(1'b0, 16'd90,    2'd0, 32'd90, 64'h3ff0000000000000, 4);
        issue(1'b0, 16'd180,   2'd1, 32'd0,  64'h0000000000000000, 4);
        issue(1'b0, 16'd270,   2'd2, 32'd90, 64'hbff0000000000000, 4);
        issue(1'b0, 16'd360,   2'd0, 32'd0,  64'h0000000000000000, 5);
        issue(1'b0, 16'd65535, 2'd0, 32'd15, 64'h3fd0907dc1930690, LAT_MAX);
        issue(1'b1, 16'd65535, 2'd1, 32'd75, 64'h3feee8dd4748bf15, LAT_MAX);

        // Backpressure: result must hold with in_ready low and no extra lookup
        n = 0;
        while ((in_ready !== 1'b1) && (n < 400)) begin
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        issue(1'b0, 16'd30, 2'd0, 32'd30, 64'h3fdfffffffffffff, 4);
        n = 0;
        while ((out_valid !== 1'b1) && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        if (out_valid !== 1'b1) fail("bp_out_valid_wait");
        snap = lut_pulses;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_out_data", out_data, 64'h3fdfffffffffffff);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        check("bp_lut_pulses", 64'(lut_pulses), 64'(snap));
        out_ready = 1'b1;
        @(negedge clk);

        // Reset while in REDUCE: pending work discarded
        issue(1'b0, 16'd65535, 2'd0, 32'd15, 64'h3fd0907dc1930690, LAT_MAX);
        repeat (5) @(negedge clk);
        snap = lut_pulses;
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_lut_en", {63'd0, lut_en}, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        exp_q.delete();
        lut_q.delete();
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("post_rst_lut_pulses", 64'(lut_pulses), 64'(snap));
        issue(1'b0, 16'd300, 2'd3, 32'd60, 64'hbfebb67ae8584caa, 4);

        n = 0;
        while (((exp_q.size() != 0) || (out_valid === 1'b1)) && (n < 500)) begin
            @(negedge clk);
            n++;
        end
        if ((exp_q.size() != 0) || (out_valid === 1'b1)) fail("drain");
        check("lut_queue_empty", 64'(lut_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
